// File: rtl/bit_deserializer.sv
// bit_deserializer: serial-to-parallel receiver with a one-word valid/ready holding register
module bit_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             in_start,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             sync_err
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr, base, word;
  logic [CW-1:0] cnt, pos;
  logic done;
  always_comb begin
    base = in_start ? '0 : sr;
    pos = in_start ? '0 : cnt;
    word = MSB_FIRST ? {base[WIDTH-2:0], in} : {in, base[WIDTH-1:1]};
    done = in_valid && pos == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      overrun <= 1'b0;
      sync_err <= 1'b0;
      if (in_valid) begin
        sr <= word;
        cnt <= done ? '0 : pos + 1'b1;
        sync_err <= in_start && cnt != '0;
      end
      if (done && (!out_valid || out_ready)) begin
        out <= word;
        out_valid <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
